// File: rtl/efuse_cfg_loader_if.sv
// Wishbone read-only link between efuse_cfg_loader (master) and efuse_ctrl (slave).
// Signal names follow the loader's point of view.
interface efuse_cfg_loader_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic        wb_sel_o;
    logic [11:0] wb_adr_o;
    logic [7:0]  wb_dat_i;
    logic        wb_ack_i;

    modport master (
        output wb_cyc_o,
        output wb_stb_o,
        output wb_we_o,
        output wb_sel_o,
        output wb_adr_o,
        input  wb_dat_i,
        input  wb_ack_i
    );

    modport slave (
        input  wb_cyc_o,
        input  wb_stb_o,
        input  wb_we_o,
        input  wb_sel_o,
        input  wb_adr_o,
        output wb_dat_i,
        output wb_ack_i
    );
endinterface

// File: rtl/efuse_cfg_loader.sv
// Boot-time loader: reads the bitstream byte by byte from efuse_ctrl over Wishbone
// and shifts each byte MSB-first into the fabric configuration chain.
module efuse_cfg_loader #(
    parameter logic [11:0] BASE_ADDR   = 12'h000,
    parameter int unsigned NUM_BYTES   = 1024,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    start_i,
    efuse_cfg_loader_if.master      wb,
    output logic                    cfg_data_o,
    output logic                    cfg_shift_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o
);

    localparam int unsigned ADR_W  = 12;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned WAIT_W = 16;
    localparam int unsigned BIT_W  = 3;

    localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(NUM_BYTES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT);
    localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SHIFT,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [ADR_W-1:0]    adr_q,   adr_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic [BIT_W-1:0]    bit_q,   bit_d;
    logic [6:0]          rem_q,   rem_d;
    logic                data_q,  data_d;
    logic                shift_q, shift_d;
    logic                cyc_q,   cyc_d;
    logic                busy_q,  busy_d;
    logic                done_q,  done_d;
    logic                err_q,   err_d;
    logic [WAIT_W-1:0]   wait_inc;

    // State and output registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            data_q  <= 1'b0;
            shift_q <= 1'b0;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wait_inc = wait_q + WAIT_W'(1);

    // Next-state logic; output registers are loaded alongside the state so every port is a flop
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        data_d  = data_q;
        shift_d = shift_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_REQ;
                    adr_d   = BASE_ADDR;
                    cnt_d   = '0;
                    wait_d  = '0;
                    cyc_d   = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end

            ST_REQ: begin
                // Ack wins over timeout when both land on the same cycle
                if (wb.wb_ack_i) begin
                    state_d = ST_SHIFT;
                    data_d  = wb.wb_dat_i[7];
                    rem_d   = wb.wb_dat_i[6:0];
                    bit_d   = '0;
                    cyc_d   = 1'b0;
                    shift_d = 1'b1;
                end else if (wait_inc == WAIT_LIMIT) begin
                    state_d = ST_ERR;
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    wait_d  = wait_inc;
                end
            end

            ST_SHIFT: begin
                if (bit_q == LAST_BIT) begin
                    shift_d = 1'b0;
                    data_d  = 1'b0;
                    if (cnt_q == LAST_BYTE) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        cnt_d   = cnt_q + CNT_W'(1);
                        adr_d   = adr_q + ADR_W'(1);
                        wait_d  = '0;
                        cyc_d   = 1'b1;
                    end
                end else begin
                    bit_d   = bit_q + BIT_W'(1);
                    data_d  = rem_q[6];
                    rem_d   = {rem_q[5:0], 1'b0};
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = 1'b0;
    assign wb.wb_sel_o = 1'b1;
    assign wb.wb_adr_o = adr_q;

    assign cfg_data_o  = data_q;
    assign cfg_shift_o = shift_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = err_q;

endmodule
